// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: instruction field layout,
// opcode and condition-code constants, and the sequencer state encoding.
package proc_pkg;

  localparam int IR_W = 16;

  localparam int COND_HI = 15;
  localparam int COND_LO = 14;
  localparam int OPCD_HI = 13;
  localparam int OPCD_LO = 10;
  localparam int DEST_HI = 9;
  localparam int DEST_LO = 7;
  localparam int SRC_HI  = 6;
  localparam int SRC_LO  = 4;
  localparam int SRC2_HI = 3;
  localparam int SRC2_LO = 0;
  localparam int JMP_HI  = 7;
  localparam int JMP_LO  = 0;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'hB;
  localparam logic [3:0] OP_LD     = 4'hC;
  localparam logic [3:0] OP_ST     = 4'hD;
  localparam logic [3:0] OP_JMP    = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [1:0] CC_AL = 2'b00;
  localparam logic [1:0] CC_Z  = 2'b01;
  localparam logic [1:0] CC_N  = 2'b10;
  localparam logic [1:0] CC_C  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  function automatic logic cond_met(input logic [1:0] cond,
                                    input logic z,
                                    input logic n,
                                    input logic c);
    logic ok;
    case (cond)
      CC_AL:   ok = 1'b1;
      CC_Z:    ok = z;
      CC_N:    ok = n;
      CC_C:    ok = c;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Bundle of ROM, datapath-control and data-memory signals between the
// instruction sequencer (master) and the rest of the processor (slave).
interface inst_sequencer_if #(parameter int PC_W = 8);

  logic            run;
  logic [PC_W-1:0] rom_addr;
  logic [15:0]     rom_data;
  logic            flag_z;
  logic            flag_n;
  logic            flag_c;
  logic [3:0]      opcd;
  logic [2:0]      dest;
  logic [2:0]      source;
  logic [3:0]      source2;
  logic            alu_en;
  logic            rf_we;
  logic            mem_req;
  logic            mem_we;
  logic            mem_ack;
  logic            halted;

  modport master (
    input  run, rom_data, flag_z, flag_n, flag_c, mem_ack,
    output rom_addr, opcd, dest, source, source2,
           alu_en, rf_we, mem_req, mem_we, halted
  );

  modport slave (
    output run, rom_data, flag_z, flag_n, flag_c, mem_ack,
    input  rom_addr, opcd, dest, source, source2,
           alu_en, rf_we, mem_req, mem_we, halted
  );

endinterface

// File: rtl/splitter.sv
// Breaks a latched instruction word into its condition, opcode and
// register-operand fields.
module splitter
  import proc_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output logic [1:0]      cond,
  output logic [3:0]      opcd,
  output logic [2:0]      dest,
  output logic [2:0]      source,
  output logic [3:0]      source2
);

  assign cond    = ir[COND_HI:COND_LO];
  assign opcd    = ir[OPCD_HI:OPCD_LO];
  assign dest    = ir[DEST_HI:DEST_LO];
  assign source  = ir[SRC_HI:SRC_LO];
  assign source2 = ir[SRC2_HI:SRC2_LO];

endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle fetch/decode/execute controller: walks the ROM by pc, gates
// each instruction on its condition code and sequences ALU, memory and write-back.
module inst_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W = 8
)(
  input logic              clk,
  input logic              rst,
  inst_sequencer_if.master bus
);

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nxt;
  logic [IR_W-1:0] ir;
  logic [IR_W-1:0] ir_nxt;

  logic [1:0] cond;
  logic [3:0] opcd;
  logic [2:0] dest;
  logic [2:0] source;
  logic [3:0] source2;
  logic       cond_ok;
  logic       is_alu;

  logic alu_en;
  logic rf_we;
  logic mem_req;
  logic mem_we;
  logic halted;

  splitter u_splitter (
    .ir      (ir),
    .cond    (cond),
    .opcd    (opcd),
    .dest    (dest),
    .source  (source),
    .source2 (source2)
  );

  assign cond_ok = cond_met(cond, bus.flag_z, bus.flag_n, bus.flag_c);
  assign is_alu  = (opcd >= OP_ALU_LO) && (opcd <= OP_ALU_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // Control strobes are pure state decodes; mem_ack only steers the next state.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    alu_en    = 1'b0;
    rf_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.run) state_nxt = S_FETCH;
      end

      S_FETCH: begin
        state_nxt = S_DECODE;
      end

      S_DECODE: begin
        ir_nxt    = bus.rom_data;
        pc_nxt    = pc + PC_W'(1);
        state_nxt = S_EXEC;
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        if (cond_ok) begin
          if (is_alu) begin
            alu_en    = 1'b1;
            state_nxt = S_WB;
          end else begin
            case (opcd)
              OP_LD, OP_ST: state_nxt = S_MEM;
              OP_JMP:       pc_nxt    = PC_W'(ir[JMP_HI:JMP_LO]);
              OP_HALT:      state_nxt = S_HALT;
              default:      state_nxt = S_FETCH;
            endcase
          end
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcd == OP_ST);
        if (bus.mem_ack) state_nxt = (opcd == OP_LD) ? S_WB : S_FETCH;
      end

      S_WB: begin
        rf_we     = 1'b1;
        state_nxt = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.rom_addr = pc;
  assign bus.opcd     = opcd;
  assign bus.dest     = dest;
  assign bus.source   = source;
  assign bus.source2  = source2;
  assign bus.alu_en   = alu_en;
  assign bus.rf_we    = rf_we;
  assign bus.mem_req  = mem_req;
  assign bus.mem_we   = mem_we;
  assign bus.halted   = halted;

  // At most one datapath strobe per cycle, and a store never appears without a request.
  a_one_strobe: assert property (@(posedge clk) disable iff (rst)
    $onehot0({alu_en, rf_we, mem_req}));
  a_we_needs_req: assert property (@(posedge clk) disable iff (rst)
    mem_we |-> mem_req);

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: table of single instructions expanded
// into per-cycle expected outputs on a scoreboard queue, plus reset/halt corner cases.
module tb_inst_sequencer;
  import proc_pkg::*;

  localparam int PC_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_sequencer_if #(.PC_W(PC_W)) bus();

  inst_sequencer #(.PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] rom [256];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Memory responder: acks on the ack_delay-th cycle of a request; stray_ack
  // holds mem_ack high whenever no request is outstanding.
  int ack_delay = 1;
  bit stray_ack = 1'b0;
  int mem_cnt   = 0;
  initial bus.mem_ack = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_req) begin
      mem_cnt     = mem_cnt + 1;
      bus.mem_ack = (mem_cnt == ack_delay);
    end else begin
      mem_cnt     = 0;
      bus.mem_ack = stray_ack;
    end
  end

  typedef struct {
    logic [7:0] rom_addr;
    logic       alu_en;
    logic       rf_we;
    logic       mem_req;
    logic       mem_we;
    logic       halted;
    logic       chk_fields;
    logic [3:0] opcd;
    logic [2:0] dest;
    logic [2:0] source;
    logic [3:0] source2;
  } cyc_t;

  typedef struct {
    string      name;
    logic [15:0] word;
    logic       fz, fn, fc;
    int         ack;
    bit         stray;
    logic [3:0] e_opcd;
    logic [2:0] e_dest;
    logic [2:0] e_src;
    logic [3:0] e_src2;
    bit         e_alu;
    bit         e_rf;
    int         e_mem;
    bit         e_we;
    bit         e_halt;
    logic [7:0] e_next;
  } vec_t;

  cyc_t exp_q[$];
  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [15:0] word,
                              logic fz, logic fn, logic fc, int ack, bit stray,
                              logic [3:0] op, logic [2:0] d, logic [2:0] s,
                              logic [3:0] s2, bit alu, bit rf, int mem, bit we,
                              bit halt, logic [7:0] nxt);
    vec_t v;
    v.name = name; v.word = word; v.fz = fz; v.fn = fn; v.fc = fc;
    v.ack = ack; v.stray = stray; v.e_opcd = op; v.e_dest = d; v.e_src = s;
    v.e_src2 = s2; v.e_alu = alu; v.e_rf = rf; v.e_mem = mem; v.e_we = we;
    v.e_halt = halt; v.e_next = nxt;
    return v;
  endfunction

  function automatic cyc_t cyc(logic [7:0] addr);
    cyc_t c;
    c.rom_addr = addr; c.alu_en = 1'b0; c.rf_we = 1'b0; c.mem_req = 1'b0;
    c.mem_we = 1'b0; c.halted = 1'b0; c.chk_fields = 1'b0;
    c.opcd = '0; c.dest = '0; c.source = '0; c.source2 = '0;
    return c;
  endfunction

  task automatic check_val(string what, logic [15:0] act, logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic check_output(string tag, cyc_t e);
    check_val({tag, " rom_addr"}, 16'(bus.rom_addr), 16'(e.rom_addr));
    check_val({tag, " alu_en"},   16'(bus.alu_en),   16'(e.alu_en));
    check_val({tag, " rf_we"},    16'(bus.rf_we),    16'(e.rf_we));
    check_val({tag, " mem_req"},  16'(bus.mem_req),  16'(e.mem_req));
    check_val({tag, " mem_we"},   16'(bus.mem_we),   16'(e.mem_we));
    check_val({tag, " halted"},   16'(bus.halted),   16'(e.halted));
    if (e.chk_fields) begin
      check_val({tag, " opcd"},    16'(bus.opcd),    16'(e.opcd));
      check_val({tag, " dest"},    16'(bus.dest),    16'(e.dest));
      check_val({tag, " source"},  16'(bus.source),  16'(e.source));
      check_val({tag, " source2"}, 16'(bus.source2), 16'(e.source2));
    end
  endtask

  function automatic cyc_t reset_cyc();
    cyc_t c;
    c = cyc(8'h00);
    c.chk_fields = 1'b1;
    return c;
  endfunction

  task automatic do_reset(string tag);
    rst = 1'b1;
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    check_output({tag, " reset"}, reset_cyc());
    rst = 1'b0;
  endtask

  // Expands one table row into the cycle-by-cycle outputs expected from the
  // instruction at pc 0 and the first three cycles of whatever follows it.
  task automatic push_instr(vec_t v);
    cyc_t c;
    logic [7:0] nx1;
    exp_q.push_back(cyc(8'h00));
    exp_q.push_back(cyc(8'h00));
    c = cyc(8'h01);
    c.alu_en = v.e_alu; c.chk_fields = 1'b1;
    c.opcd = v.e_opcd; c.dest = v.e_dest; c.source = v.e_src; c.source2 = v.e_src2;
    exp_q.push_back(c);
    for (int k = 0; k < v.e_mem; k++) begin
      c = cyc(8'h01);
      c.mem_req = 1'b1; c.mem_we = v.e_we;
      exp_q.push_back(c);
    end
    if (v.e_rf) begin
      c = cyc(8'h01);
      c.rf_we = 1'b1;
      exp_q.push_back(c);
    end
    if (v.e_halt) begin
      for (int k = 0; k < 4; k++) begin
        c = cyc(8'h01);
        c.halted = 1'b1;
        exp_q.push_back(c);
      end
    end else begin
      nx1 = v.e_next + 8'd1;
      exp_q.push_back(cyc(v.e_next));
      exp_q.push_back(cyc(v.e_next));
      exp_q.push_back(cyc(nx1));
    end
  endtask

  task automatic apply_stimulus(vec_t v);
    cyc_t e;
    int   n;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    rom[0]     = v.word;
    bus.flag_z = v.fz;
    bus.flag_n = v.fn;
    bus.flag_c = v.fc;
    ack_delay  = v.ack;
    stray_ack  = v.stray;
    do_reset(v.name);
    push_instr(v);
    bus.run = 1'b1;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.run = 1'b0;
      e = exp_q.pop_front();
      check_output($sformatf("%s c%0d", v.name, n), e);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    cyc_t c;
    int   waited;
    bus.run = 1'b0;
    bus.flag_z = 1'b0; bus.flag_n = 1'b0; bus.flag_c = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;

    //                name        word     z  n  c  ack st op    d  s  s2   alu rf mem we hlt next
    vecs.push_back(mk("nop",      16'h0000, 0, 0, 0, 1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h01));
    vecs.push_back(mk("alu_al",   16'h04A0, 0, 0, 0, 1, 0, 4'h1, 1, 2, 4'h0, 1, 1, 0, 0, 0, 8'h01));
    vecs.push_back(mk("alu_zf",   16'h4990, 0, 1, 1, 1, 0, 4'h2, 3, 1, 4'h0, 0, 0, 0, 0, 0, 8'h01));
    vecs.push_back(mk("alu_zt",   16'h4990, 1, 0, 0, 1, 0, 4'h2, 3, 1, 4'h0, 1, 1, 0, 0, 0, 8'h01));
    vecs.push_back(mk("alu_nt",   16'hAE65, 0, 1, 0, 1, 0, 4'hB, 4, 6, 4'h5, 1, 1, 0, 0, 0, 8'h01));
    vecs.push_back(mk("alu_cf",   16'hCC00, 1, 1, 0, 1, 0, 4'h3, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h01));
    vecs.push_back(mk("alu_ct",   16'hEBFF, 0, 0, 1, 1, 0, 4'hA, 7, 7, 4'hF, 1, 1, 0, 0, 0, 8'h01));
    vecs.push_back(mk("ld_k3",    16'h3280, 0, 0, 0, 3, 0, 4'hC, 5, 0, 4'h0, 0, 1, 3, 0, 0, 8'h01));
    vecs.push_back(mk("st_k1",    16'h3530, 0, 0, 0, 1, 0, 4'hD, 2, 3, 4'h0, 0, 0, 1, 1, 0, 8'h01));
    vecs.push_back(mk("st_k2_sa", 16'h3530, 0, 0, 0, 2, 1, 4'hD, 2, 3, 4'h0, 0, 0, 2, 1, 0, 8'h01));
    vecs.push_back(mk("ld_zf",    16'h7000, 0, 1, 1, 1, 0, 4'hC, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h01));
    vecs.push_back(mk("jmp_ff",   16'h38FF, 0, 0, 0, 1, 0, 4'hE, 1, 7, 4'hF, 0, 0, 0, 0, 0, 8'hFF));
    vecs.push_back(mk("jmp_self", 16'h3800, 0, 0, 0, 1, 0, 4'hE, 0, 0, 4'h0, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk("halt",     16'h3C00, 0, 0, 0, 1, 0, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0, 1, 8'h01));

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // HALT (left over from the last row) ignores run and leaves only via rst.
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      c = cyc(8'h01);
      c.halted = 1'b1;
      check_output("halt_hold", c);
    end
    rst = 1'b1;
    @(negedge clk);
    check_output("halt_rst", reset_cyc());
    bus.run = 1'b0;
    rst = 1'b0;

    // rst and run together: rst wins, the sequencer must still be idle afterwards.
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    stray_ack = 1'b0;
    rst = 1'b1;
    bus.run = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("rst_run_idle", cyc(8'h00));
    end

    // Reset while a load is stalled in MEM abandons the request.
    rom[0]    = 16'h3280;
    ack_delay = 1000;
    do_reset("rst_mem");
    bus.run = 1'b1;
    waited  = 0;
    do begin
      @(negedge clk);
      bus.run = 1'b0;
      waited++;
    end while (!bus.mem_req && waited < 20);
    check_val("rst_mem wait_cycles", 16'(waited), 16'd4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      c = cyc(8'h01);
      c.mem_req = 1'b1;
      check_output("rst_mem stall", c);
    end
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_mem after", reset_cyc());
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rst_mem idle", reset_cyc());
    end
    bus.run = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.run = 1'b0;
      check_val($sformatf("rst_mem restart mem_req c%0d", i),
                16'(bus.mem_req), (i == 4) ? 16'd1 : 16'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
